edge_detect_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-bit rise/fall detector.
- Each channel has an input synchroniser, an optional debounce filter, registered rise/fall pulses, a per-channel mode-qualified event pulse and a sticky event flag with software clear.
- Sits between asynchronous external inputs (keys, switches, GPIO) and the downstream control logic or interrupt aggregation.

---
 rtl/edge_detect_multi.sv | 145 ++++++++++++++
 tb/tb_edge_detect_multi.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: multi-channel input conditioner.
// Each channel synchronises a raw asynchronous input and optionally debounces it.
// It then produces registered rise/fall pulses, a mode-qualified event pulse and a
// sticky event flag that software can clear. irq is the registered OR of all sticky bits.
module edge_detect_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 0,
  parameter int DEB_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     a,
  input  logic [2*CH-1:0]   mode,
  input  logic [CH-1:0]     clr,
  output logic [CH-1:0]     level,
  output logic [CH-1:0]     rise,
  output logic [CH-1:0]     down,
  output logic [CH-1:0]     pulse,
  output logic [CH-1:0]     sticky,
  output logic              irq
);

  // DEB_CYCLES of 0 and 1 both mean "accept a new level on the first differing cycle".
  localparam int unsigned      DEB_D    = (DEB_CYCLES < 1) ? 1 : DEB_CYCLES;
  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_D - 1);
  localparam logic [DEB_W-1:0] CNT_ONE  = DEB_W'(1);

  logic [CH-1:0]    sync_q [SYNC_STAGES];
  logic [CH-1:0]    sync_d [SYNC_STAGES];
  logic [CH-1:0]    sync_s;

  logic [DEB_W-1:0] cnt_q  [CH];
  logic [DEB_W-1:0] cnt_d  [CH];
  logic [CH-1:0]    level_q, level_d;

  logic [CH-1:0]    rise_q, rise_d;
  logic [CH-1:0]    down_q, down_d;
  logic [CH-1:0]    pulse_q, pulse_d;
  logic [CH-1:0]    sticky_q, sticky_d;
  logic             irq_q, irq_d;

  logic [CH-1:0]    mode_rise;
  logic [CH-1:0]    mode_fall;

  // Shift register chain: stage 0 samples the raw pins, each later stage copies the one before.
  always_comb begin
    sync_d[0] = a;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser flops; these are the only flops that see the raw asynchronous pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  // Debounce: count consecutive cycles where the synchronised input disagrees with level.
  // Adopt the new value only after DEB_D such cycles in a row.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = sync_s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Debounce counters and filtered level; reset aborts any count in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q <= level_d;
    end
  end

  // Split the packed 2-bit-per-channel mode bus into rise and fall enables.
  always_comb begin
    mode_rise = '0;
    mode_fall = '0;
    for (int i = 0; i < CH; i++) begin
      mode_rise[i] = mode[2*i];
      mode_fall[i] = mode[2*i+1];
    end
  end

  // Edge pulses and qualification are derived from the level transition of this same edge.
  // In the sticky term, set has priority over clear, and irq tracks the next sticky value.
  always_comb begin
    rise_d   = level_d & ~level_q;
    down_d   = ~level_d & level_q;
    pulse_d  = (rise_d & mode_rise) | (down_d & mode_fall);
    sticky_d = (sticky_q & ~clr) | pulse_d;
    irq_d    = |sticky_d;
  end

  // Event output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q   <= '0;
      down_q   <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      down_q   <= down_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      irq_q    <= irq_d;
    end
  end

  assign level  = level_q;
  assign rise   = rise_q;
  assign down   = down_q;
  assign pulse  = pulse_q;
  assign sticky = sticky_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Testbench for edge_detect_multi.
// Three instances share one set of inputs and differ only in debounce length (0, 4 and 8).
// A window-based reference model predicts every output of every instance each cycle.
module tb_edge_detect_multi;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int NI   = 3;
  localparam int HLEN = SYNC + 8;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   a;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   clr;

  logic [CH-1:0]   oLevel  [NI];
  logic [CH-1:0]   oRise   [NI];
  logic [CH-1:0]   oDown   [NI];
  logic [CH-1:0]   oPulse  [NI];
  logic [CH-1:0]   oSticky [NI];
  logic            oIrq    [NI];

  logic [CH-1:0]   mLevel  [NI];
  logic [CH-1:0]   mRise   [NI];
  logic [CH-1:0]   mDown   [NI];
  logic [CH-1:0]   mPulse  [NI];
  logic [CH-1:0]   mSticky [NI];
  logic            mIrq    [NI];

  logic [CH-1:0]   hist[$];
  logic [CH-1:0]   smp;
  bit              allHi, allLo;
  logic            nl;

  int checks = 0;
  int errors = 0;

  edge_detect_multi #(.CH(CH), .SYNC_STAGES(SYNC), .DEB_CYCLES(0), .DEB_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .mode(mode), .clr(clr),
    .level(oLevel[0]), .rise(oRise[0]), .down(oDown[0]), .pulse(oPulse[0]),
    .sticky(oSticky[0]), .irq(oIrq[0])
  );

  edge_detect_multi #(.CH(CH), .SYNC_STAGES(SYNC), .DEB_CYCLES(4), .DEB_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a), .mode(mode), .clr(clr),
    .level(oLevel[1]), .rise(oRise[1]), .down(oDown[1]), .pulse(oPulse[1]),
    .sticky(oSticky[1]), .irq(oIrq[1])
  );

  edge_detect_multi #(.CH(CH), .SYNC_STAGES(SYNC), .DEB_CYCLES(8), .DEB_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .mode(mode), .clr(clr),
    .level(oLevel[2]), .rise(oRise[2]), .down(oDown[2]), .pulse(oPulse[2]),
    .sticky(oSticky[2]), .irq(oIrq[2])
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Effective debounce length of each instance.
  function automatic int deff(input int n);
    case (n)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  // Reference model: hist[k] holds the input sampled k edges ago (hist[0] is this edge).
  // The synchroniser delays a sample by SYNC edges. A level flips once the last D
  // synchronised samples all agree on the opposite value.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      for (int k = 0; k < HLEN; k++) hist.push_back('0);
      for (int n = 0; n < NI; n++) begin
        mLevel[n] = '0; mRise[n] = '0; mDown[n] = '0;
        mPulse[n] = '0; mSticky[n] = '0; mIrq[n] = 1'b0;
      end
    end else begin
      hist.push_front(a);
      void'(hist.pop_back());
      for (int n = 0; n < NI; n++) begin
        for (int ch = 0; ch < CH; ch++) begin
          allHi = 1'b1;
          allLo = 1'b1;
          for (int k = SYNC; k < SYNC + deff(n); k++) begin
            smp = hist[k];
            if (smp[ch]) allLo = 1'b0;
            else         allHi = 1'b0;
          end
          nl = mLevel[n][ch];
          if (allHi)      nl = 1'b1;
          else if (allLo) nl = 1'b0;
          mRise[n][ch]   = nl & ~mLevel[n][ch];
          mDown[n][ch]   = ~nl & mLevel[n][ch];
          mLevel[n][ch]  = nl;
          mPulse[n][ch]  = (mRise[n][ch] & mode[2*ch]) | (mDown[n][ch] & mode[2*ch+1]);
          mSticky[n][ch] = (mSticky[n][ch] & ~clr[ch]) | mPulse[n][ch];
        end
        mIrq[n] = |mSticky[n];
      end
    end
  end

  // Compare every output of every instance against the model.
  task automatic checkOutput(input string tag);
    for (int n = 0; n < NI; n++) begin
      checks++;
      assert ({oLevel[n], oRise[n], oDown[n], oPulse[n], oSticky[n], oIrq[n]} ===
              {mLevel[n], mRise[n], mDown[n], mPulse[n], mSticky[n], mIrq[n]})
      else begin
        errors++;
        $error("[TB] FAIL %s inst%0d observed lvl/r/d/p/s/irq=%h/%h/%h/%h/%h/%b expected %h/%h/%h/%h/%h/%b",
               tag, n, oLevel[n], oRise[n], oDown[n], oPulse[n], oSticky[n], oIrq[n],
               mLevel[n], mRise[n], mDown[n], mPulse[n], mSticky[n], mIrq[n]);
      end
    end
  endtask

  // Directed comparison against a hand-derived constant.
  task automatic checkBits(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, then check at the next falling edge.
  task automatic applyStimulus(input logic [CH-1:0] aV, input logic [2*CH-1:0] mV,
                               input logic [CH-1:0] cV, input string tag);
    a    = aV;
    mode = mV;
    clr  = cV;
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    logic [CH-1:0] ra;
    rst_n = 1'b1;
    a     = '1;
    mode  = 8'h55;
    clr   = '0;
    #1 rst_n = 1'b0;

    $display("[TB] reset with all inputs high");
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset");
      checkBits("resetZero", {11'd0, oLevel[0], oRise[0], oPulse[0], oSticky[0], oIrq[0]}, 32'd0);
    end
    rst_n = 1'b1;

    applyStimulus(4'hF, 8'h55, 4'h0, "relE1");
    applyStimulus(4'hF, 8'h55, 4'h0, "relE2");
    checkBits("preRise", {28'd0, oRise[0]}, 32'd0);
    applyStimulus(4'hF, 8'h55, 4'h0, "relE3");
    checkBits("riseAll", {16'd0, oLevel[0], oRise[0], oPulse[0], oSticky[0]}, 32'h0000_FFFF);
    checkBits("irqSet", {31'd0, oIrq[0]}, 32'd1);
    applyStimulus(4'hF, 8'h55, 4'h0, "relE4");
    checkBits("riseWidth", {28'd0, oRise[0]}, 32'd0);
    repeat (8) applyStimulus(4'hF, 8'h55, 4'h0, "settleHigh");

    $display("[TB] clear stickies and return inputs low");
    applyStimulus(4'hF, 8'h55, 4'hF, "clrIdle");
    repeat (12) applyStimulus(4'h0, 8'h55, 4'h0, "fallAll");
    applyStimulus(4'h0, 8'h55, 4'hF, "clrIdle2");
    checkBits("stickyCleared", {20'd0, oSticky[0], oSticky[1], oSticky[2]}, 32'd0);

    $display("[TB] latency and pulse width on channel 0");
    applyStimulus(4'h1, 8'h55, 4'h0, "latE0");
    applyStimulus(4'h1, 8'h55, 4'h0, "latE1");
    checkBits("latEarly", {28'd0, oRise[0]}, 32'd0);
    applyStimulus(4'h1, 8'h55, 4'h0, "latE2");
    checkBits("latRise", {20'd0, oRise[0], oPulse[0], oSticky[0]}, 32'h0000_0111);
    applyStimulus(4'h1, 8'h55, 4'h0, "latE3");
    checkBits("latWidth", {24'd0, oRise[0], oPulse[0]}, 32'd0);
    repeat (10) applyStimulus(4'h1, 8'h55, 4'h0, "latHold");
    repeat (12) applyStimulus(4'h0, 8'h55, 4'h0, "latFall");

    $display("[TB] short glitch and stable pulse on channel 1");
    applyStimulus(4'h0, 8'hFF, 4'hF, "glClr");
    repeat (3) applyStimulus(4'h2, 8'hFF, 4'h0, "glitch");
    repeat (10) applyStimulus(4'h0, 8'hFF, 4'h0, "glAfter");
    checkBits("glNoSticky", {31'd0, oSticky[1][1]}, 32'd0);
    repeat (4) applyStimulus(4'h2, 8'hFF, 4'h0, "stable4");
    repeat (12) applyStimulus(4'h0, 8'hFF, 4'h0, "stableAfter");

    $display("[TB] both-edge mode and sticky clear on channel 2");
    repeat (12) applyStimulus(4'h4, 8'h30, 4'h0, "bothHi");
    repeat (12) applyStimulus(4'h0, 8'h30, 4'h0, "bothLo");
    applyStimulus(4'h0, 8'h30, 4'h4, "bothClr");
    for (int k = 0; k < 12; k++) applyStimulus(4'h4, 8'h30, (k == 2) ? 4'h4 : 4'h0, "setWins");
    repeat (12) applyStimulus(4'h0, 8'h30, 4'h0, "bothTail");

    $display("[TB] simultaneous channels with channel 1 off");
    applyStimulus(4'h0, 8'h41, 4'hF, "simClr");
    applyStimulus(4'hB, 8'h41, 4'h0, "simE0");
    applyStimulus(4'hB, 8'h41, 4'h0, "simE1");
    applyStimulus(4'hB, 8'h41, 4'h0, "simE2");
    checkBits("simOut", {20'd0, oRise[0], oPulse[0], oSticky[0]}, 32'h0000_0B99);
    repeat (10) applyStimulus(4'hB, 8'h41, 4'h0, "simHold");
    repeat (12) applyStimulus(4'h0, 8'h41, 4'h0, "simFall");

    $display("[TB] reset in the middle of a debounce count");
    repeat (5) applyStimulus(4'hF, 8'hFF, 4'h0, "preReset");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncReset");
    checkBits("asyncZero", {15'd0, oLevel[2], oRise[2], oSticky[2], oLevel[0], oIrq[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) applyStimulus(4'hF, 8'hFF, 4'h0, "postReset");
    checkBits("fullLatency", {28'd0, oLevel[2]}, 32'd0);
    applyStimulus(4'hF, 8'hFF, 4'h0, "postRise");
    checkBits("riseAfterReset", {28'd0, oRise[2]}, 32'h0000_000F);

    $display("[TB] randomized traffic");
    ra = 4'hF;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < CH; b++) begin
        if ($urandom_range(0, 5) == 0) ra[b] = ~ra[b];
      end
      if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
      applyStimulus(ra, mode, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
